// File: rtl/mouse_pkg.sv
// Shared constants and types for the mouse position tracker.
package mouse_pkg;
  localparam int MDELTA_W = 9;
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;

  typedef enum logic {IDLE, DRAG} drag_state_e;
endpackage

// File: rtl/mouse_pos_tracker_if.sv
// Movement-packet input, position load and cursor/button outputs of the tracker.
interface mouse_pos_tracker_if import mouse_pkg::*; #(parameter int POS_W = 14);
  logic                m_done_tick;
  logic [MDELTA_W-1:0] xm;
  logic [MDELTA_W-1:0] ym;
  logic [2:0]          btnm;
  logic                set_en;
  logic [POS_W-1:0]    set_x;
  logic [POS_W-1:0]    set_y;
  logic [POS_W-1:0]    pos_x;
  logic [POS_W-1:0]    pos_y;
  logic                upd;
  logic [2:0]          btn;
  logic [2:0]          btn_press;
  logic [2:0]          btn_release;
  logic                drag;

  modport master (
    output m_done_tick, xm, ym, btnm, set_en, set_x, set_y,
    input  pos_x, pos_y, upd, btn, btn_press, btn_release, drag
  );
  modport slave (
    input  m_done_tick, xm, ym, btnm, set_en, set_x, set_y,
    output pos_x, pos_y, upd, btn, btn_press, btn_release, drag
  );
endinterface

// File: rtl/mouse_pos_tracker_axis_accum.sv
// One axis: stage 1 scales the packet delta, stage 2 adds it with clamp or wrap.
module axis_accum import mouse_pkg::*; #(
  parameter int POS_W      = 14,
  parameter int MAX        = 6400,
  parameter int INIT       = 3200,
  parameter int GAIN_SHIFT = 1,
  parameter bit WRAP       = 1'b0,
  parameter bit INVERT     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                v1,
  input  logic                set_en,
  input  logic [MDELTA_W-1:0] delta,
  input  logic [POS_W-1:0]    set_val,
  output logic [POS_W-1:0]    pos
);
  // Wide enough for pos plus the largest scaled delta without any truncation.
  localparam int S_W = POS_W + GAIN_SHIFT + 11;
  localparam logic signed [S_W-1:0] MAX_S = S_W'(MAX);
  localparam logic signed [S_W-1:0] SPAN  = S_W'(MAX + 1);

  if ((256 << GAIN_SHIFT) > MAX + 1) begin : g_chk_span
    $error("axis_accum: scaled delta range exceeds MAX+1");
  end
  if (MAX >= (1 << POS_W)) begin : g_chk_max
    $error("axis_accum: MAX does not fit in POS_W");
  end
  if (INIT > MAX) begin : g_chk_init
    $error("axis_accum: INIT above MAX");
  end

  logic signed [S_W-1:0] sd_ext, sd, sum;
  logic [POS_W-1:0]      nxt;

  assign sd_ext = S_W'($signed(delta)) <<< GAIN_SHIFT;
  assign sum    = $signed({{(S_W-POS_W){1'b0}}, pos}) + sd;

  always_comb begin
    nxt = POS_W'(sum);
    if (sum < 0)
      nxt = WRAP ? POS_W'(sum + SPAN) : '0;
    else if (sum > MAX_S)
      nxt = WRAP ? POS_W'(sum - SPAN) : POS_W'(MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd  <= '0;
      pos <= POS_W'(INIT);
    end else begin
      if (tick)
        sd <= INVERT ? -sd_ext : sd_ext;
      // A load overrides a stage-2 update landing on the same edge.
      if (set_en)
        pos <= (set_val > POS_W'(MAX)) ? POS_W'(MAX) : set_val;
      else if (v1)
        pos <= nxt;
    end
  end
endmodule

// File: rtl/mouse_pos_tracker.sv
// Cursor tracker: two axis accumulators, button edge decode and left-drag FSM.
module mouse_pos_tracker import mouse_pkg::*; #(
  parameter int POS_W      = 14,
  parameter int X_MAX      = 6400,
  parameter int Y_MAX      = 4800,
  parameter int X_INIT     = 3200,
  parameter int Y_INIT     = 2400,
  parameter int GAIN_SHIFT = 1,
  parameter bit WRAP       = 1'b0,
  parameter bit Y_INVERT   = 1'b1
) (
  input logic clk,
  input logic rst,
  mouse_pos_tracker_if.slave bus
);
  logic        v1;
  drag_state_e state, state_d;

  axis_accum #(
    .POS_W(POS_W), .MAX(X_MAX), .INIT(X_INIT),
    .GAIN_SHIFT(GAIN_SHIFT), .WRAP(WRAP), .INVERT(1'b0)
  ) u_x (
    .clk(clk), .rst(rst), .tick(bus.m_done_tick), .v1(v1), .set_en(bus.set_en),
    .delta(bus.xm), .set_val(bus.set_x), .pos(bus.pos_x)
  );

  axis_accum #(
    .POS_W(POS_W), .MAX(Y_MAX), .INIT(Y_INIT),
    .GAIN_SHIFT(GAIN_SHIFT), .WRAP(WRAP), .INVERT(Y_INVERT)
  ) u_y (
    .clk(clk), .rst(rst), .tick(bus.m_done_tick), .v1(v1), .set_en(bus.set_en),
    .delta(bus.ym), .set_val(bus.set_y), .pos(bus.pos_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1              <= 1'b0;
      bus.upd         <= 1'b0;
      bus.btn         <= '0;
      bus.btn_press   <= '0;
      bus.btn_release <= '0;
    end else begin
      v1      <= bus.m_done_tick;
      bus.upd <= v1 | bus.set_en;
      if (bus.m_done_tick) begin
        bus.btn         <= bus.btnm;
        bus.btn_press   <= bus.btnm & ~bus.btn;
        bus.btn_release <= ~bus.btnm & bus.btn;
      end else begin
        bus.btn_press   <= '0;
        bus.btn_release <= '0;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.btn_press[BTN_L])   state_d = DRAG;
      DRAG:    if (bus.btn_release[BTN_L]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.drag <= 1'b0;
    end else begin
      state    <= state_d;
      bus.drag <= (state_d == DRAG);
    end
  end
endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Drives three tracker configurations in lockstep and checks them against a scoreboard.
module tb_mouse_pos_tracker;
  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [8:0] xm, ym;
  logic [2:0] btnm;
  logic       set_en;
  logic [13:0] set_x, set_y;

  always #5 clk = ~clk;

  mouse_pos_tracker_if #(.POS_W(14)) b0 ();
  mouse_pos_tracker_if #(.POS_W(14)) b1 ();
  mouse_pos_tracker_if #(.POS_W(14)) b2 ();

  assign b0.m_done_tick = tick;   assign b1.m_done_tick = tick;   assign b2.m_done_tick = tick;
  assign b0.xm = xm;              assign b1.xm = xm;              assign b2.xm = xm;
  assign b0.ym = ym;              assign b1.ym = ym;              assign b2.ym = ym;
  assign b0.btnm = btnm;          assign b1.btnm = btnm;          assign b2.btnm = btnm;
  assign b0.set_en = set_en;      assign b1.set_en = set_en;      assign b2.set_en = set_en;
  assign b0.set_x = set_x;        assign b1.set_x = set_x;        assign b2.set_x = set_x;
  assign b0.set_y = set_y;        assign b1.set_y = set_y;        assign b2.set_y = set_y;

  mouse_pos_tracker u0 (.clk(clk), .rst(rst), .bus(b0));
  mouse_pos_tracker #(.Y_INVERT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mouse_pos_tracker #(.X_MAX(639), .X_INIT(320), .GAIN_SHIFT(0), .WRAP(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  logic [13:0] dpx [3];
  logic [13:0] dpy [3];
  logic        dupd [3];
  assign dpx[0] = b0.pos_x; assign dpx[1] = b1.pos_x; assign dpx[2] = b2.pos_x;
  assign dpy[0] = b0.pos_y; assign dpy[1] = b1.pos_y; assign dpy[2] = b2.pos_y;
  assign dupd[0] = b0.upd;  assign dupd[1] = b1.upd;  assign dupd[2] = b2.upd;

  // Per-instance configuration mirrored from the instantiations above.
  int cxm [3] = '{6400, 6400, 639};
  int cym [3] = '{4800, 4800, 4800};
  int cxi [3] = '{3200, 3200, 320};
  int cyi [3] = '{2400, 2400, 2400};
  int cg  [3] = '{1, 1, 0};
  bit cw  [3] = '{1'b0, 1'b0, 1'b1};
  bit cinv[3] = '{1'b1, 1'b0, 1'b1};

  int px [3];
  int py [3];
  int qdue [$];
  int qpos [$];
  int cnum = 0;
  int ntests = 0;
  int nfail = 0;
  logic [2:0] mbtn, mpress, mrel;
  bit mst, mdrag;

  function automatic int mv(int p, int d, int mx, int g, bit wr, bit inv);
    int s;
    s = inv ? p - (d * (1 << g)) : p + (d * (1 << g));
    if (s < 0) s = wr ? s + mx + 1 : 0;
    else if (s > mx) s = wr ? s - mx - 1 : mx;
    return s;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin px[i] = cxi[i]; py[i] = cyi[i]; end
    qdue.delete(); qpos.delete();
    mbtn = '0; mpress = '0; mrel = '0; mst = 1'b0; mdrag = 1'b0;
  endtask

  task automatic push(int due);
    qdue.push_back(due);
    for (int i = 0; i < 3; i++) begin qpos.push_back(px[i]); qpos.push_back(py[i]); end
  endtask

  task automatic cyc();
    logic [2:0] nb, np, nr;
    bit ns;
    int e;
    bit eu;
    ns = mst;
    if (!mst && mpress[0]) ns = 1'b1;
    else if (mst && mrel[0]) ns = 1'b0;
    if (tick) begin nb = btnm; np = btnm & ~mbtn; nr = ~btnm & mbtn; end
    else begin nb = mbtn; np = '0; nr = '0; end
    @(posedge clk); #1;
    cnum++;
    if (rst) model_reset();
    else begin mbtn = nb; mpress = np; mrel = nr; mst = ns; mdrag = ns; end
    chk("btn", b0.btn, mbtn);
    chk("btn_press", b0.btn_press, mpress);
    chk("btn_release", b0.btn_release, mrel);
    chk("drag", b0.drag, mdrag);
    eu = (qdue.size() > 0) && (qdue[0] == cnum);
    for (int i = 0; i < 3; i++) chk($sformatf("upd%0d", i), dupd[i], eu);
    if (eu) begin
      void'(qdue.pop_front());
      for (int i = 0; i < 3; i++) begin
        e = qpos.pop_front(); chk($sformatf("pos_x%0d", i), dpx[i], e);
        e = qpos.pop_front(); chk($sformatf("pos_y%0d", i), dpy[i], e);
      end
    end
  endtask

  task automatic pkt(logic [8:0] dx, logic [8:0] dy, logic [2:0] b, bit p);
    tick = 1'b1; xm = dx; ym = dy; btnm = b;
    if (p) begin
      for (int i = 0; i < 3; i++) begin
        px[i] = mv(px[i], int'($signed(dx)), cxm[i], cg[i], cw[i], 1'b0);
        py[i] = mv(py[i], int'($signed(dy)), cym[i], cg[i], cw[i], cinv[i]);
      end
      push(cnum + 2);
    end
    cyc();
    tick = 1'b0; xm = '0; ym = '0;
  endtask

  task automatic load(int sx, int sy);
    set_en = 1'b1; set_x = 14'(sx); set_y = 14'(sy);
    for (int i = 0; i < 3; i++) begin
      px[i] = (sx > cxm[i]) ? cxm[i] : sx;
      py[i] = (sy > cym[i]) ? cym[i] : sy;
    end
    push(cnum + 1);
    cyc();
    set_en = 1'b0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic chk_reset_vals(string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_pos_x"}, dpx[i], cxi[i]);
      chk({tag, "_pos_y"}, dpy[i], cyi[i]);
      chk({tag, "_upd"}, dupd[i], 0);
    end
    chk({tag, "_btn"}, b0.btn, 0);
    chk({tag, "_drag"}, b0.drag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; xm = '0; ym = '0; btnm = '0;
    set_en = 1'b0; set_x = '0; set_y = '0;
    model_reset();
    #2;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic X/Y movement, both Y senses
    pkt(9'h005, 9'h000, 3'b000, 1'b1); idle(2);
    pkt(9'h1FB, 9'h000, 3'b000, 1'b1); idle(2);
    pkt(9'h000, 9'h005, 3'b000, 1'b1); idle(2);

    // Saturation at both edges, upd still pulses
    load(6395, 100); pkt(9'd100, 9'h000, 3'b000, 1'b1); idle(2);
    load(4, 4800);   pkt(9'h19C, 9'h000, 3'b000, 1'b1); idle(2);

    // Wrap edges and back-to-back packets
    load(630, 2400); pkt(9'd10, 9'h000, 3'b000, 1'b1); idle(2);
    pkt(9'h1FF, 9'h000, 3'b000, 1'b1); idle(2);
    load(0, 2400);
    pkt(9'd1, 9'h000, 3'b000, 1'b1);
    pkt(9'd1, 9'h000, 3'b000, 1'b1);
    pkt(9'd1, 9'h000, 3'b000, 1'b1);
    idle(3);

    // Button edges and drag
    pkt(9'h000, 9'h000, 3'b001, 1'b1); idle(2);
    pkt(9'h000, 9'h000, 3'b001, 1'b1); idle(2);
    pkt(9'h000, 9'h000, 3'b110, 1'b1); idle(2);
    pkt(9'h000, 9'h000, 3'b000, 1'b1); idle(2);

    // Load collides with stage 2: the delta is dropped
    pkt(9'd5, 9'd5, 3'b000, 1'b0);
    load(100, 100); idle(2);
    load(9000, 9000); idle(2);

    // Async reset with a packet in flight
    pkt(9'd7, 9'd7, 3'b001, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    cyc();
    rst = 1'b0;
    idle(3);
    chk("queue_drained", qdue.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
